debounce_bank: RTL

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 79 +++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-flop synchronizer and 4-state debounce FSM with registered press/release pulses.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a channel is held high.
module debounce_bank #(
  parameter int          CH         = 4,
  parameter int          CW         = 16,
  parameter int unsigned N          = 16'hffff,
  parameter int          RW         = 24,
  parameter int unsigned REPEAT_DLY = 24'd5000000,
  parameter int unsigned REPEAT_PER = 24'd1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] I,
  output logic [CH-1:0] Y,
  output logic [CH-1:0] press,
  output logic [CH-1:0] rel
);
  typedef enum logic [1:0] {IDLE = 2'b00, RISE = 2'b01, HIGH = 2'b11, FALL = 2'b10} state_t;
  localparam logic [CW-1:0] NT = CW'(N);
  if (CH < 1 || CH > 32 || N < 1 || 64'(N) >= (64'd1 << CW) || RW < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
    $error("debounce_bank: parameter out of range");
  end
`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [RW-1:0] RD = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RP = RW'(REPEAT_PER - 1);
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [1:0]    sync;
    logic          s;
    state_t        st, nx;
    logic [CW-1:0] c;
    logic          rise_ev, fall_ev, rep, pr, rl;
    assign s = sync[1];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sync <= '0;
        st   <= IDLE;
        c    <= '0;
        pr   <= 1'b0;
        rl   <= 1'b0;
      end else begin
        sync <= {sync[0], I[i]};
        st   <= nx;
        c    <= (st == RISE || st == FALL) ? c + 1'b1 : '0;
        pr   <= rise_ev | rep;
        rl   <= fall_ev;
      end
    always_comb begin
      nx      = st;
      rise_ev = st == RISE && s && c == NT;
      fall_ev = st == FALL && !s && c == NT;
      case (st)
        IDLE:    nx = s ? RISE : IDLE;
        RISE:    nx = !s ? IDLE : rise_ev ? HIGH : RISE;
        HIGH:    nx = s ? HIGH : FALL;
        default: nx = s ? HIGH : fall_ev ? IDLE : FALL;
      endcase
    end
`ifdef DEBOUNCE_REPEAT_EN
    logic [RW-1:0] r;
    logic          rf;
    // rf remembers the first repeat was issued; a FALL bounce keeps it so repeats resume at the period
    assign rep = st == HIGH && r == (rf ? RP : RD);
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r  <= '0;
        rf <= 1'b0;
      end else begin
        r  <= (st == HIGH && !rep) ? r + 1'b1 : '0;
        rf <= st == HIGH ? (rf | rep) : (st == FALL && rf);
      end
`else
    assign rep = 1'b0;
`endif
    assign Y[i]     = st[1];
    assign press[i] = pr;
    assign rel[i]   = rl;
  end
endmodule
